// File: rtl/multicore_prog_loader_pkg.sv
// Shared definitions for the multicore program loader: opcodes, header layout, FSM states.
package multicore_loader_pkg;

    // Header opcodes (bits [31:30]); 2'b11 is illegal
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;

    // Header field layout
    localparam int unsigned HDR_W    = 32;
    localparam int unsigned OP_LSB   = 30;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned MASK_LSB = 22;
    localparam int unsigned MASK_W   = 8;
    localparam int unsigned ADRS_LSB = 11;
    localparam int unsigned ADRS_W   = 11;
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned LEN_W    = 11;
    localparam int unsigned CHK_W    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/multicore_prog_loader_if.sv
// Stream input and core-side write/run outputs of the program loader.
interface multicore_prog_loader_if #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADRS_WIDTH = 11,
    parameter int unsigned NUM_CORES  = 2
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_SIZE-1:0]  s_data;
    logic [NUM_CORES-1:0]  w_enable;
    logic [ADRS_WIDTH-1:0] w_adrs;
    logic [DATA_SIZE-1:0]  w_instruction;
    logic [NUM_CORES-1:0]  cpu_en;
    logic                  busy;
    logic                  err;
    logic [31:0]           checksum;

    // Host side: drives the word stream, observes loader outputs
    modport master (
        output s_valid, s_data,
        input  s_ready, w_enable, w_adrs, w_instruction, cpu_en, busy, err, checksum
    );

    // Loader side
    modport slave (
        input  s_valid, s_data,
        output s_ready, w_enable, w_adrs, w_instruction, cpu_en, busy, err, checksum
    );
endinterface

// File: rtl/multicore_prog_loader_hdr_decode.sv
// Combinational splitter of a command header into opcode, core mask, address and length.
module prog_hdr_decode
    import multicore_loader_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADRS_WIDTH = 11,
    parameter int unsigned NUM_CORES  = 2
) (
    input  logic [DATA_SIZE-1:0]  hdr,
    output logic [OP_W-1:0]       opcode_c,
    output logic [NUM_CORES-1:0]  mask_c,
    output logic [ADRS_WIDTH-1:0] adrs_c,
    output logic [LEN_W-1:0]      len_c,
    output logic                  illegal_c
);
    logic [HDR_W-1:0]  word;
    logic [MASK_W-1:0] mask_field;
    logic [ADRS_W-1:0] adrs_field;
    logic              unused_bits;

    // Mask bits above NUM_CORES and address bits above ADRS_WIDTH are dropped
    assign word       = hdr[HDR_W-1:0];
    assign opcode_c   = word[OP_LSB +: OP_W];
    assign mask_field = word[MASK_LSB +: MASK_W];
    assign adrs_field = word[ADRS_LSB +: ADRS_W];
    assign len_c      = word[LEN_LSB +: LEN_W];
    assign mask_c     = mask_field[NUM_CORES-1:0];
    assign adrs_c     = adrs_field[ADRS_WIDTH-1:0];
    assign illegal_c  = (opcode_c == 2'b11);

    assign unused_bits = ^{hdr, mask_field, adrs_field};

endmodule

// File: rtl/multicore_prog_loader.sv
// Command-driven program loader: streams payload into selected cores' memories and
// gates their cpu_en. Optional feature macro: LOADER_CHECKSUM_EN (payload checksum).
module multicore_prog_loader
    import multicore_loader_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADRS_WIDTH = 11,
    parameter int unsigned NUM_CORES  = 2
) (
    input  logic                   sys_clk,
    input  logic                   resetn,
    multicore_prog_loader_if.slave bus
);
    state_t                state;
    logic [NUM_CORES-1:0]  load_mask;
    logic [ADRS_WIDTH-1:0] cur_adrs;
    logic [LEN_W-1:0]      remaining;

    logic                  s_ready_q;
    logic [NUM_CORES-1:0]  w_enable_q;
    logic [ADRS_WIDTH-1:0] w_adrs_q;
    logic [DATA_SIZE-1:0]  w_instr_q;
    logic [NUM_CORES-1:0]  cpu_en_q;
    logic                  busy_q;
    logic                  err_q;

    logic [OP_W-1:0]       opcode_c;
    logic [NUM_CORES-1:0]  mask_c;
    logic [ADRS_WIDTH-1:0] adrs_c;
    logic [LEN_W-1:0]      len_c;
    logic                  illegal_c;
    logic                  accept_c;

    prog_hdr_decode #(
        .DATA_SIZE (DATA_SIZE),
        .ADRS_WIDTH(ADRS_WIDTH),
        .NUM_CORES (NUM_CORES)
    ) u_hdr_decode (
        .hdr      (bus.s_data),
        .opcode_c (opcode_c),
        .mask_c   (mask_c),
        .adrs_c   (adrs_c),
        .len_c    (len_c),
        .illegal_c(illegal_c)
    );

    assign accept_c = bus.s_valid & s_ready_q;

    // Loader FSM with registered outputs; every accepted word takes effect next cycle
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            load_mask  <= '0;
            cur_adrs   <= '0;
            remaining  <= '0;
            s_ready_q  <= 1'b1;
            w_enable_q <= '0;
            w_adrs_q   <= '0;
            w_instr_q  <= '0;
            cpu_en_q   <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s_ready_q  <= 1'b1;
            w_enable_q <= '0;
            if (accept_c) begin
                case (state)
                    IDLE: begin
                        if (illegal_c) begin
                            err_q <= 1'b1;
                        end else begin
                            case (opcode_c)
                                OP_LOAD: begin
                                    load_mask <= mask_c;
                                    cur_adrs  <= adrs_c;
                                    remaining <= len_c;
                                    cpu_en_q  <= cpu_en_q & ~mask_c;
                                    if (len_c != '0) begin
                                        state  <= LOAD;
                                        busy_q <= 1'b1;
                                    end
                                end
                                OP_RUN:  cpu_en_q <= cpu_en_q | mask_c;
                                OP_HALT: cpu_en_q <= cpu_en_q & ~mask_c;
                                default: ;
                            endcase
                        end
                    end
                    LOAD: begin
                        w_enable_q <= load_mask;
                        w_adrs_q   <= cur_adrs;
                        w_instr_q  <= bus.s_data;
                        cur_adrs   <= cur_adrs + ADRS_WIDTH'(1);
                        remaining  <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [CHK_W-1:0] checksum_q;

    // Running sum of payload words, restarted by each LOAD header
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            checksum_q <= '0;
        end else if (accept_c) begin
            if (state == IDLE && !illegal_c && opcode_c == OP_LOAD) begin
                checksum_q <= '0;
            end else if (state == LOAD) begin
                checksum_q <= checksum_q + bus.s_data[CHK_W-1:0];
            end
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = 32'h0;
`endif

    assign bus.s_ready       = s_ready_q;
    assign bus.w_enable      = w_enable_q;
    assign bus.w_adrs        = w_adrs_q;
    assign bus.w_instruction = w_instr_q;
    assign bus.cpu_en        = cpu_en_q;
    assign bus.busy          = busy_q;
    assign bus.err           = err_q;

endmodule
